// File: rtl/sync_frame_controller.sv
// sync_frame_controller
// Finds the Schmidl-Cox metric peak in a window after a threshold crossing,
// then emits one frame of delayed samples starting at the peak (+offset).
//
// Ports:
//   clk, reset, clear          clock, sync active-high reset / clear
//   threshold                  detection threshold (used in SEARCH only)
//   m_tdata/m_tlast/m_tvalid   metric stream in (m_tlast ignored), m_tready out
//   i_tdata/i_tlast/i_tvalid   sample stream in (i_tlast ignored), i_tready out
//   o_tdata/o_tlast/o_tvalid   framed sample stream out, o_tready in
//   det_stb/det_peak/det_offset  detection pulse, peak value, peak index
module sync_frame_controller #(
    parameter int unsigned CP_SIZE      = 128,
    parameter int unsigned PEAK_WINDOW  = 128,
    parameter int unsigned START_OFFSET = 0,
    parameter int unsigned FRAME_LEN    = 16128,
    localparam int unsigned MW = 32 + $clog2(CP_SIZE + 1),
    localparam int unsigned OW = $clog2(PEAK_WINDOW + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic [MW-1:0] threshold,
    input  logic [MW-1:0] m_tdata,
    input  logic          m_tlast,
    input  logic          m_tvalid,
    output logic          m_tready,
    input  logic [31:0]   i_tdata,
    input  logic          i_tlast,
    input  logic          i_tvalid,
    output logic          i_tready,
    output logic [31:0]   o_tdata,
    output logic          o_tlast,
    output logic          o_tvalid,
    input  logic          o_tready,
    output logic          det_stb,
    output logic [MW-1:0] det_peak,
    output logic [OW-1:0] det_offset
);

    localparam int unsigned PW = (PEAK_WINDOW > 1) ? $clog2(PEAK_WINDOW) : 1;
    localparam int unsigned SW = $clog2(PEAK_WINDOW + START_OFFSET + 1);
    localparam int unsigned FW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

    localparam logic [1:0] SEARCH = 2'd0;
    localparam logic [1:0] PEAK   = 2'd1;
    localparam logic [1:0] SKIP   = 2'd2;
    localparam logic [1:0] FRAME  = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [OW-1:0] cnt_q, cnt_d;
    logic [OW-1:0] idx_q, idx_d;
    logic [MW-1:0] peak_q, peak_d;
    logic [SW-1:0] skip_q, skip_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic          det_stb_q, det_stb_d;
    logic [MW-1:0] det_peak_q, det_peak_d;
    logic [OW-1:0] det_offset_q, det_offset_d;
    logic [PW-1:0] wptr_q;
    logic [31:0]   ring_q [PEAK_WINDOW];

    logic          rst_any;
    logic          adv;
    logic          accept;
    logic          last_beat;
    logic [MW-1:0] peak_sel;
    logic [OW-1:0] idx_sel;
    logic [SW-1:0] skip_new;
    logic          unused_tlast;

    assign unused_tlast = &{1'b0, m_tlast, i_tlast};

    // Joint handshake: both streams move together, stalled only by the output in FRAME.
    assign rst_any  = reset | clear;
    assign adv      = (state_q != FRAME) | o_tready;
    assign i_tready = m_tvalid & adv;
    assign m_tready = i_tvalid & adv;
    assign accept   = i_tvalid & m_tvalid & adv;

    // Oldest ring entry is the sample leaving the delay line on this accept.
    assign o_tdata   = ring_q[wptr_q];
    assign o_tvalid  = (state_q == FRAME) & i_tvalid & m_tvalid;
    assign last_beat = (fcnt_q == FW'(FRAME_LEN - 1));
    assign o_tlast   = (state_q == FRAME) & last_beat;

    assign det_stb    = det_stb_q;
    assign det_peak   = det_peak_q;
    assign det_offset = det_offset_q;

    // Delay line storage; contents need no reset since pre-reset data is always dropped.
    always_ff @(posedge clk) begin
        if (accept && !rst_any) begin
            ring_q[wptr_q] <= i_tdata;
        end
    end

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (rst_any) begin
            state_q      <= SEARCH;
            cnt_q        <= '0;
            idx_q        <= '0;
            peak_q       <= '0;
            skip_q       <= '0;
            fcnt_q       <= '0;
            det_stb_q    <= 1'b0;
            det_peak_q   <= '0;
            det_offset_q <= '0;
            wptr_q       <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            peak_q       <= peak_d;
            skip_q       <= skip_d;
            fcnt_q       <= fcnt_d;
            det_stb_q    <= det_stb_d;
            det_peak_q   <= det_peak_d;
            det_offset_q <= det_offset_d;
            if (accept) begin
                wptr_q <= (wptr_q == PW'(PEAK_WINDOW - 1)) ? '0 : wptr_q + PW'(1);
            end
        end
    end

    // Next-state logic; everything advances only on an accepted sample.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        peak_d       = peak_q;
        skip_d       = skip_q;
        fcnt_d       = fcnt_q;
        det_stb_d    = 1'b0;
        det_peak_d   = det_peak_q;
        det_offset_d = det_offset_q;
        peak_sel     = peak_q;
        idx_sel      = idx_q;
        skip_new     = '0;

        if (accept) begin
            case (state_q)
                SEARCH: begin
                    if (m_tdata > threshold) begin
                        peak_d = m_tdata;
                        idx_d  = '0;
                        cnt_d  = OW'(1);
                        if (PEAK_WINDOW == 1) begin
                            // One-sample window: the crossing sample is the peak.
                            det_stb_d    = 1'b1;
                            det_peak_d   = m_tdata;
                            det_offset_d = '0;
                            skip_d       = SW'(START_OFFSET);
                            fcnt_d       = '0;
                            state_d      = (START_OFFSET == 0) ? FRAME : SKIP;
                        end else begin
                            state_d = PEAK;
                        end
                    end
                end
                PEAK: begin
                    // Strict compare keeps the first maximum on ties.
                    if (m_tdata > peak_q) begin
                        peak_sel = m_tdata;
                        idx_sel  = cnt_q;
                    end
                    peak_d = peak_sel;
                    idx_d  = idx_sel;
                    cnt_d  = cnt_q + OW'(1);
                    if (cnt_q == OW'(PEAK_WINDOW - 1)) begin
                        skip_new     = SW'(idx_sel) + SW'(START_OFFSET);
                        det_stb_d    = 1'b1;
                        det_peak_d   = peak_sel;
                        det_offset_d = idx_sel;
                        skip_d       = skip_new;
                        fcnt_d       = '0;
                        // With nothing to skip the very next leaving sample starts the frame.
                        state_d      = (skip_new == '0) ? FRAME : SKIP;
                    end
                end
                SKIP: begin
                    skip_d = skip_q - SW'(1);
                    if (skip_q <= SW'(1)) begin
                        skip_d  = '0;
                        fcnt_d  = '0;
                        state_d = FRAME;
                    end
                end
                default: begin
                    fcnt_d = fcnt_q + FW'(1);
                    if (last_beat) begin
                        fcnt_d  = '0;
                        state_d = SEARCH;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sync_frame_controller.sv
module tb_sync_frame_controller;

    localparam int MW = 40;
    localparam int OW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, clear, m_tvalid, i_tvalid, o_tready;
    logic [MW-1:0] threshold, m_tdata;
    logic [31:0]   i_tdata;

    logic          m_tready0, i_tready0, o_tvalid0, o_tlast0, det_stb0;
    logic [31:0]   o_tdata0;
    logic [MW-1:0] det_peak0;
    logic [OW-1:0] det_offset0;
    logic          m_tready4, i_tready4, o_tvalid4, o_tlast4, det_stb4;
    logic [31:0]   o_tdata4;
    logic [MW-1:0] det_peak4;
    logic [OW-1:0] det_offset4;

    sync_frame_controller #(.PEAK_WINDOW(8), .START_OFFSET(0), .FRAME_LEN(16)) dut (
        .clk(clk), .reset(reset), .clear(clear), .threshold(threshold),
        .m_tdata(m_tdata), .m_tlast(1'b0), .m_tvalid(m_tvalid), .m_tready(m_tready0),
        .i_tdata(i_tdata), .i_tlast(1'b0), .i_tvalid(i_tvalid), .i_tready(i_tready0),
        .o_tdata(o_tdata0), .o_tlast(o_tlast0), .o_tvalid(o_tvalid0), .o_tready(o_tready),
        .det_stb(det_stb0), .det_peak(det_peak0), .det_offset(det_offset0));

    sync_frame_controller #(.PEAK_WINDOW(8), .START_OFFSET(4), .FRAME_LEN(16)) dut_off (
        .clk(clk), .reset(reset), .clear(clear), .threshold(threshold),
        .m_tdata(m_tdata), .m_tlast(1'b0), .m_tvalid(m_tvalid), .m_tready(m_tready4),
        .i_tdata(i_tdata), .i_tlast(1'b0), .i_tvalid(i_tvalid), .i_tready(i_tready4),
        .o_tdata(o_tdata4), .o_tlast(o_tlast4), .o_tvalid(o_tvalid4), .o_tready(o_tready),
        .det_stb(det_stb4), .det_peak(det_peak4), .det_offset(det_offset4));

    int n_pass = 0;
    int n_chk  = 0;
    int n, cyc, first0_cyc, vld_cnt, rdy_lo_cnt, bp_vio, stalls;
    int unsigned out0_d[$], out4_d[$];
    bit          out0_l[$], out4_l[$];
    logic [MW-1:0] det0_pk[$], det4_pk[$];
    int          det0_off[$], det0_cyc[$], det4_off[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    endtask

    function automatic logic [MW-1:0] met(input int scen, input int idx);
        if (scen == 1) return MW'(100);
        if (scen == 3) begin
            case (idx)
                100: return MW'(2000);
                101: return MW'(1500);
                102: return MW'(4000);
                103: return MW'(3000);
                104: return MW'(3500);
                105: return MW'(4000);
                106: return MW'(1200);
                107: return MW'(1100);
                default: return MW'(500);
            endcase
        end
        case (idx)
            100: return MW'(2000);
            101: return MW'(3000);
            103: return MW'(5000);
            102, 104, 105, 106, 107: return MW'(1000);
            150: return MW'(2500);
            default: return MW'(500);
        endcase
    endfunction

    task automatic do_reset(input bit do_chk);
        reset = 1'b1; clear = 1'b0; i_tvalid = 1'b1; m_tvalid = 1'b1; o_tready = 1'b1;
        i_tdata = '0; m_tdata = '0; threshold = MW'(1000);
        repeat (2) @(posedge clk);
        @(negedge clk);
        if (do_chk) begin
            chk("rst_o_tvalid", 64'(o_tvalid0), 64'(0));
            chk("rst_o_tlast", 64'(o_tlast0), 64'(0));
            chk("rst_det_stb", 64'(det_stb0), 64'(0));
            chk("rst_det_peak", 64'(det_peak0), 64'(0));
            chk("rst_det_offset", 64'(det_offset0), 64'(0));
            chk("rst_i_tready", 64'(i_tready0), 64'(1));
        end
        @(posedge clk); #1;
        reset = 1'b0;
        out0_d.delete(); out0_l.delete(); out4_d.delete(); out4_l.delete();
        det0_pk.delete(); det0_off.delete(); det0_cyc.delete();
        det4_pk.delete(); det4_off.delete();
        first0_cyc = -1; vld_cnt = 0; rdy_lo_cnt = 0; bp_vio = 0; stalls = 0;
    endtask

    task automatic run(input int scen, input int nmax, input bit bp, input bit clr_mid);
        bit cleared, chk_clr, acc, do_clr;
        cleared = 1'b0; chk_clr = 1'b0;
        n = 0; cyc = 0;
        while (n < nmax && cyc < 4 * nmax + 100) begin
            do_clr   = clr_mid && !cleared && (out0_d.size() == 5);
            i_tdata  = 32'(n);
            m_tdata  = met(scen, n);
            o_tready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            clear    = do_clr;
            @(negedge clk);
            if (chk_clr) begin
                chk("clr_det_peak", 64'(det_peak0), 64'(0));
                chk("clr_det_offset", 64'(det_offset0), 64'(0));
                chk("clr_o_tvalid", 64'(o_tvalid0), 64'(0));
                chk_clr = 1'b0;
            end
            acc = 1'b0;
            if (!do_clr) begin
                acc = i_tready0;
                if (o_tvalid0 && o_tready) begin
                    if (out0_d.size() == 0) first0_cyc = cyc;
                    out0_d.push_back(o_tdata0); out0_l.push_back(o_tlast0);
                end
                if (o_tvalid4 && o_tready) begin
                    out4_d.push_back(o_tdata4); out4_l.push_back(o_tlast4);
                end
                if (!i_tready0) rdy_lo_cnt++;
                if (o_tvalid0) vld_cnt++;
                if (o_tvalid0 && !o_tready) stalls++;
                if (o_tvalid0 && !o_tready && (i_tready0 || m_tready0)) bp_vio++;
            end
            if (det_stb0) begin
                det0_pk.push_back(det_peak0); det0_off.push_back(int'(det_offset0));
                det0_cyc.push_back(cyc);
            end
            if (det_stb4) begin
                det4_pk.push_back(det_peak4); det4_off.push_back(int'(det_offset4));
            end
            @(posedge clk); #1;
            clear = 1'b0;
            if (do_clr) begin cleared = 1'b1; chk_clr = 1'b1; end
            if (acc) n++;
            cyc++;
        end
        chk($sformatf("s%0d_samples_done", scen), 64'(n), 64'(nmax));
    endtask

    initial begin
        // 1: no detection
        do_reset(1'b1);
        run(1, 5000, 1'b0, 1'b0);
        chk("s1_o_tvalid_cycles", 64'(vld_cnt), 64'(0));
        chk("s1_det_count", 64'(det0_pk.size()), 64'(0));
        chk("s1_i_tready_low", 64'(rdy_lo_cnt), 64'(0));

        // 2 + 4: single peak, then a later crossing; offset instance alongside
        do_reset(1'b0);
        run(2, 180, 1'b0, 1'b0);
        chk("s2_det_count", 64'(det0_pk.size()), 64'(2));
        if (det0_pk.size() == 2) begin
            chk("s2_det_peak0", 64'(det0_pk[0]), 64'(5000));
            chk("s2_det_off0", 64'(det0_off[0]), 64'(3));
            chk("s2_det_cyc0", 64'(det0_cyc[0]), 64'(108));
            chk("s2_det_peak1", 64'(det0_pk[1]), 64'(2500));
            chk("s2_det_off1", 64'(det0_off[1]), 64'(0));
            chk("s2_det_cyc1", 64'(det0_cyc[1]), 64'(158));
        end
        chk("s2_first_out_cyc", 64'(first0_cyc), 64'(111));
        chk("s2_out_count", 64'(out0_d.size()), 64'(32));
        for (int i = 0; i < out0_d.size() && i < 32; i++) begin
            chk($sformatf("s2_data%0d", i), 64'(out0_d[i]), 64'((i < 16) ? 103 + i : 150 + i - 16));
            chk($sformatf("s2_last%0d", i), 64'(out0_l[i]), 64'(i == 15 || i == 31));
        end
        chk("s4_det_count", 64'(det4_pk.size()), 64'(2));
        if (det4_pk.size() == 2) begin
            chk("s4_det_peak0", 64'(det4_pk[0]), 64'(5000));
            chk("s4_det_off0", 64'(det4_off[0]), 64'(3));
        end
        chk("s4_out_count", 64'(out4_d.size()), 64'(32));
        for (int i = 0; i < out4_d.size() && i < 32; i++) begin
            chk($sformatf("s4_data%0d", i), 64'(out4_d[i]), 64'((i < 16) ? 107 + i : 154 + i - 16));
            chk($sformatf("s4_last%0d", i), 64'(out4_l[i]), 64'(i == 15 || i == 31));
        end

        // 3: tie keeps the first maximum
        do_reset(1'b0);
        run(3, 140, 1'b0, 1'b0);
        chk("s3_det_count", 64'(det0_pk.size()), 64'(1));
        if (det0_pk.size() == 1) begin
            chk("s3_det_peak", 64'(det0_pk[0]), 64'(4000));
            chk("s3_det_off", 64'(det0_off[0]), 64'(2));
        end
        chk("s3_out_count", 64'(out0_d.size()), 64'(16));
        for (int i = 0; i < out0_d.size() && i < 16; i++) begin
            chk($sformatf("s3_data%0d", i), 64'(out0_d[i]), 64'(102 + i));
            chk($sformatf("s3_last%0d", i), 64'(out0_l[i]), 64'(i == 15));
        end

        // 5: random output backpressure
        do_reset(1'b0);
        run(2, 140, 1'b1, 1'b0);
        chk("s5_out_count", 64'(out0_d.size()), 64'(16));
        for (int i = 0; i < out0_d.size() && i < 16; i++) begin
            chk($sformatf("s5_data%0d", i), 64'(out0_d[i]), 64'(103 + i));
            chk($sformatf("s5_last%0d", i), 64'(out0_l[i]), 64'(i == 15));
        end
        chk("s5_ready_during_stall", 64'(bp_vio), 64'(0));
        chk("s5_saw_stall", 64'(stalls > 0), 64'(1));

        // 6: clear after five frame transfers
        do_reset(1'b0);
        run(2, 180, 1'b0, 1'b1);
        chk("s6_out_count", 64'(out0_d.size()), 64'(21));
        for (int i = 0; i < out0_d.size() && i < 21; i++) begin
            chk($sformatf("s6_data%0d", i), 64'(out0_d[i]), 64'((i < 5) ? 103 + i : 150 + i - 5));
            chk($sformatf("s6_last%0d", i), 64'(out0_l[i]), 64'(i == 20));
        end
        chk("s6_det_count", 64'(det0_pk.size()), 64'(2));
        if (det0_pk.size() == 2) chk("s6_det_peak1", 64'(det0_pk[1]), 64'(2500));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
